// File: rtl/vita2k_pkg.sv
// rtl/vita2k_pkg.sv - shared pixel width, frame defaults and frame_writer state type
package vita2k_pkg;

  localparam int PIX_W           = 64;
  localparam int BURST_LEN_DEF   = 16;
  localparam int FRAME_WORDS_DEF = 259200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } fw_state_t;

endpackage

// File: rtl/frame_writer_if.sv
// rtl/frame_writer_if.sv - memory-side burst port (valid/ready, address, data, last)
interface frame_writer_if #(
  parameter int ADDR_W = 24
);
  import vita2k_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data;
  logic              mem_last;

  modport master (output mem_valid, mem_addr, mem_data, mem_last, input mem_ready);
  modport slave  (input mem_valid, mem_addr, mem_data, mem_last, output mem_ready);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = count == CNT_W'(DEPTH);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && (count != '0);
  assign rd_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_ok) store[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - buffers recorder words and drains them as fixed-length memory bursts
// Optional FRAME_WRITER_STATS_EN adds drop_count and peak_level outputs.
module frame_writer
  import vita2k_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_LEN   = BURST_LEN_DEF,
  parameter int ADDR_W      = 24,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                        par_clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        we,
  input  logic [PIX_W-1:0]            pixels,
  input  logic [ADDR_W-1:0]           frame_base,
  frame_writer_if.master              mem,
  output logic                        frame_done,
  output logic                        overflow,
  output logic                        frame_error
`ifdef FRAME_WRITER_STATS_EN
  ,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] peak_level
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);

  if (FRAME_WORDS % BURST_LEN != 0) begin : g_frame_check
    $error("frame_writer: FRAME_WORDS must be a multiple of BURST_LEN");
  end

  fw_state_t         state;
  fw_state_t         state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [WC_W-1:0]   word_cnt;
  logic [BC_W-1:0]   beat_cnt;
  logic              done_q;
  logic              ovf_q;
  logic              err_q;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [PIX_W-1:0]  fifo_head;
  logic              accept_start;
  logic              take_word;
  logic              wr_en;
  logic              drop;
  logic              fire;
  logic              last_beat;
  logic              frame_end;

  // A start pulse in IDLE opens the frame in the same cycle, so its word is kept.
  assign accept_start = frame_start && (state == IDLE);
  assign take_word    = we && ((state != IDLE) || accept_start);
  assign wr_en        = take_word && !fifo_full;
  assign drop         = take_word && fifo_full;
  assign fire         = mem.mem_valid && mem.mem_ready;
  assign last_beat    = beat_cnt == BC_W'(BURST_LEN - 1);
  assign frame_end    = fire && last_beat && (word_cnt == WC_W'(FRAME_WORDS - 1));

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (par_clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (pixels),
    .rd_en   (fire),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign mem.mem_valid = state == BURST;
  assign mem.mem_last  = mem.mem_valid && last_beat;
  assign mem.mem_data  = mem.mem_valid ? fifo_head : '0;
  assign mem.mem_addr  = addr_q;
  assign frame_done    = done_q;
  assign overflow      = ovf_q;
  assign frame_error   = err_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = WAIT;
      WAIT:    if (fifo_count >= CNT_W'(BURST_LEN)) state_next = BURST;
      BURST:   if (fire && last_beat) state_next = frame_end ? IDLE : WAIT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge par_clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      word_cnt <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= frame_end;
      if (accept_start) begin
        addr_q   <= frame_base;
        word_cnt <= '0;
        beat_cnt <= '0;
        ovf_q    <= drop;
        err_q    <= 1'b0;
      end else begin
        if (fire) begin
          addr_q   <= addr_q + ADDR_W'(1);
          word_cnt <= word_cnt + WC_W'(1);
          beat_cnt <= last_beat ? '0 : beat_cnt + BC_W'(1);
        end
        if (drop) ovf_q <= 1'b1;
        if (frame_start) err_q <= 1'b1;
      end
    end
  end

`ifdef FRAME_WRITER_STATS_EN
  always_ff @(posedge par_clock) begin
    if (reset) begin
      drop_count <= '0;
      peak_level <= '0;
    end else if (accept_start) begin
      drop_count <= drop ? 16'd1 : 16'd0;
      peak_level <= '0;
    end else begin
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (fifo_count > peak_level) peak_level <= fifo_count;
    end
  end
`endif

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - randomized and directed bench for frame_writer against a queue-based model
module tb_frame_writer;
  import vita2k_pkg::*;

  localparam int FD = 32;
  localparam int BL = 16;
  localparam int AW = 24;
  localparam int FW = 32;

  logic          par_clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          we = 1'b0;
  logic [63:0]   pixels = '0;
  logic [AW-1:0] frame_base = '0;
  logic          mem_ready = 1'b0;
  logic          frame_done;
  logic          overflow;
  logic          frame_error;
`ifdef FRAME_WRITER_STATS_EN
  logic [15:0]          drop_count;
  logic [$clog2(FD):0]  peak_level;
`endif

  frame_writer_if #(.ADDR_W(AW)) mem_bus ();
  assign mem_bus.mem_ready = mem_ready;

  frame_writer #(
    .FIFO_DEPTH  (FD),
    .BURST_LEN   (BL),
    .ADDR_W      (AW),
    .FRAME_WORDS (FW)
  ) dut (
    .par_clock   (par_clock),
    .reset       (reset),
    .frame_start (frame_start),
    .we          (we),
    .pixels      (pixels),
    .frame_base  (frame_base),
    .mem         (mem_bus),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_error (frame_error)
`ifdef FRAME_WRITER_STATS_EN
    ,
    .drop_count  (drop_count),
    .peak_level  (peak_level)
`endif
  );

  always #5 par_clock = ~par_clock;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [63:0]   q[$];
  bit            live = 0;
  bit            m_active = 0;
  bit            m_ovf = 0;
  bit            m_err = 0;
  bit            m_done = 0;
  logic [AW-1:0] m_base = '0;
  int            m_idx = 0;
  int            m_drops = 0;
  int            m_peak = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [63:0]   prev_data;
  int            fire_count = 0;
  int            done_count = 0;
  int            fire_cyc[$];
  logic [AW-1:0] fire_addr[$];
  bit            fire_last[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge par_clock) cyc <= cyc + 1;

  always @(posedge par_clock) begin
    #1;
    case (ready_mode)
      1: mem_ready = ~mem_ready;
      2: mem_ready = 1'($urandom_range(1));
      default: ;
    endcase
  end

  // Compare the DUT against the model, then advance the model by the coming edge.
  always @(negedge par_clock) begin
    logic [AW-1:0] ea;
    int            pre_size;
    bit            start_acc;
    bit            active_w;
    if (live) begin
      chk("frame_done", 64'(frame_done), 64'(m_done));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("frame_error", 64'(frame_error), 64'(m_err));
`ifdef FRAME_WRITER_STATS_EN
      chk("drop_count", 64'(drop_count), 64'((m_drops > 65535) ? 65535 : m_drops));
      chk("peak_level", 64'(peak_level), 64'(m_peak));
`endif
      if (frame_done) done_count++;
      if (prev_stall) begin
        chk("stall_valid", 64'(mem_bus.mem_valid), 64'(1));
        chk("stall_addr", 64'(mem_bus.mem_addr), 64'(prev_addr));
        chk("stall_data", mem_bus.mem_data, prev_data);
      end
      if (mem_bus.mem_valid) begin
        ea = m_base + AW'(m_idx);
        chk("valid_expected", 64'(mem_bus.mem_valid), 64'(m_active && (q.size() > 0)));
        if (q.size() > 0) chk("beat_data", mem_bus.mem_data, q[0]);
        chk("beat_addr", 64'(mem_bus.mem_addr), 64'(ea));
        chk("beat_last", 64'(mem_bus.mem_last), 64'((m_idx % BL) == (BL - 1)));
      end
    end
    if (reset) begin
      q.delete();
      m_active = 0; m_ovf = 0; m_err = 0; m_done = 0;
      m_idx = 0; m_drops = 0; m_peak = 0; prev_stall = 0;
      live = 1;
    end else if (live) begin
      pre_size  = q.size();
      start_acc = frame_start && !m_active;
      active_w  = m_active || start_acc;
      m_done    = 0;
      if (start_acc) begin
        m_base = frame_base; m_idx = 0; m_ovf = 0; m_err = 0;
        m_drops = 0; m_peak = 0; m_active = 1;
      end else begin
        if (frame_start) m_err = 1;
        if (pre_size > m_peak) m_peak = pre_size;
      end
      if (mem_bus.mem_valid && mem_ready && (q.size() > 0)) begin
        void'(q.pop_front());
        fire_count++;
        fire_cyc.push_back(cyc);
        fire_addr.push_back(mem_bus.mem_addr);
        fire_last.push_back(mem_bus.mem_last);
        m_idx++;
        if (m_idx == FW) begin
          m_active = 0;
          m_done = 1;
        end
      end
      if (we && active_w) begin
        if (pre_size < FD) q.push_back(pixels);
        else begin
          m_ovf = 1;
          m_drops++;
        end
      end
      prev_stall = mem_bus.mem_valid && !mem_ready;
      prev_addr  = mem_bus.mem_addr;
      prev_data  = mem_bus.mem_data;
    end
  end

  task automatic tick();
    @(posedge par_clock);
    #1;
  endtask

  task automatic clear_log();
    fire_cyc.delete();
    fire_addr.delete();
    fire_last.delete();
  endtask

  task automatic start_frame(input logic [AW-1:0] base);
    frame_start = 1'b1;
    frame_base  = base;
    we          = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      we     = 1'b1;
      pixels = {$urandom, $urandom};
      tick();
    end
    we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0 = done_count;
    int k = 0;
    while (done_count == d0 && k < limit) begin
      tick();
      k++;
    end
    chk(name, 64'(done_count > d0), 64'(1));
  endtask

  initial begin
    int s;
    int d0;
    int k;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 64'(mem_bus.mem_valid), 64'(0));
    chk("rst_addr", 64'(mem_bus.mem_addr), 64'(0));
    chk("rst_data", mem_bus.mem_data, 64'(0));
    chk("rst_last", 64'(mem_bus.mem_last), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_error", 64'(frame_error), 64'(0));

    // Words with no frame open must be ignored entirely.
    mem_ready = 1'b1;
    send_words(6);
    repeat (4) tick();
    chk("idle_overflow", 64'(overflow), 64'(0));
    chk("idle_no_beats", 64'(fire_count), 64'(0));
    chk("idle_valid", 64'(mem_bus.mem_valid), 64'(0));

    // Nominal frame at 0x100 with ready held high.
    clear_log();
    d0 = done_count;
    s = cyc;
    start_frame(24'h000100);
    send_words(FW);
    wait_done("nom_done", 200);
    repeat (3) tick();
    chk("nom_beats", 64'(fire_addr.size()), 64'(32));
    if (fire_addr.size() == 32) begin
      chk("nom_addr0", 64'(fire_addr[0]), 64'h100);
      chk("nom_addr15", 64'(fire_addr[15]), 64'h10F);
      chk("nom_addr16", 64'(fire_addr[16]), 64'h110);
      chk("nom_addr31", 64'(fire_addr[31]), 64'h11F);
      chk("nom_last14", 64'(fire_last[14]), 64'(0));
      chk("nom_last15", 64'(fire_last[15]), 64'(1));
      chk("nom_last31", 64'(fire_last[31]), 64'(1));
      chk("nom_first_latency", 64'(fire_cyc[0] - s), 64'(18));
      chk("nom_burst_len", 64'(fire_cyc[15] - fire_cyc[0]), 64'(15));
      chk("nom_gap", 64'(fire_cyc[16] - fire_cyc[15] >= 2), 64'(1));
    end
    chk("nom_one_done", 64'(done_count - d0), 64'(1));

    // Backpressure: ready toggles every cycle.
    clear_log();
    ready_mode = 1;
    start_frame(24'h003000 | AW'($urandom_range(4095)));
    send_words(FW);
    wait_done("bp_done", 400);
    ready_mode = 0;
    chk("bp_beats", 64'(fire_addr.size()), 64'(32));

    // Overflow: memory stalled while 40 words arrive into a 32-deep FIFO.
    clear_log();
    mem_ready = 1'b0;
    start_frame(24'h000200);
    send_words(40);
    repeat (2) tick();
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_model_drops", 64'(m_drops), 64'(8));
`ifdef FRAME_WRITER_STATS_EN
    chk("ovf_drop_count", 64'(drop_count), 64'(8));
    chk("ovf_peak", 64'(peak_level), 64'(32));
`endif
    mem_ready = 1'b1;
    wait_done("ovf_done", 300);
    chk("ovf_beats", 64'(fire_addr.size()), 64'(32));

    // Stray start while a burst is in flight.
    clear_log();
    start_frame(24'h005000);
    send_words(20);
    chk("stray_in_burst", 64'(mem_bus.mem_valid), 64'(1));
    frame_start = 1'b1;
    frame_base  = 24'h000ABC;
    we          = 1'b1;
    pixels      = {$urandom, $urandom};
    tick();
    frame_start = 1'b0;
    send_words(11);
    chk("stray_error", 64'(frame_error), 64'(1));
    wait_done("stray_done", 300);
    if (fire_addr.size() == 32) begin
      chk("stray_addr0", 64'(fire_addr[0]), 64'h5000);
      chk("stray_addr31", 64'(fire_addr[31]), 64'h501F);
    end else chk("stray_beats", 64'(fire_addr.size()), 64'(32));

    // Reset while beat 5 is on the bus.
    clear_log();
    start_frame(24'h000400);
    k = 0;
    while (fire_addr.size() < 5 && k < 60) begin
      we = 1'b1;
      pixels = {$urandom, $urandom};
      tick();
      k++;
    end
    chk("rmb_reached_beat5", 64'(fire_addr.size()), 64'(5));
    reset = 1'b1; mem_ready = 1'b0; we = 1'b0;
    tick();
    chk("rmb_valid_low", 64'(mem_bus.mem_valid), 64'(0));
    reset = 1'b0;
    tick();
    chk("rmb_idle_valid", 64'(mem_bus.mem_valid), 64'(0));
    mem_ready = 1'b1;
    clear_log();
    start_frame(24'h000800);
    send_words(FW);
    wait_done("rmb_done", 300);
    if (fire_addr.size() > 0) chk("rmb_first_addr", 64'(fire_addr[0]), 64'h800);
    else chk("rmb_first_addr_seen", 64'(fire_addr.size()), 64'(32));

    // Randomized frames: sparse writes, random ready, stray starts, wrap-around base.
    for (int f = 0; f < 4; f++) begin
      ready_mode = 2;
      start_frame((f == 0) ? 24'hFFFFF0 : AW'($urandom));
      d0 = done_count;
      k = 0;
      while (done_count == d0 && k < 3000) begin
        we          = ($urandom_range(99) < 70);
        pixels      = {$urandom, $urandom};
        frame_start = ($urandom_range(99) < 2);
        frame_base  = AW'($urandom);
        tick();
        k++;
      end
      we = 1'b0;
      frame_start = 1'b0;
      chk("rand_frame_done", 64'(done_count > d0), 64'(1));
      ready_mode = 0;
      mem_ready = 1'b1;
      repeat (5) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Downstream of the recorder on the `par_clock` domain. Buffers the recorder's 64-bit `pixels` words (qualified by `we`) in an internal FIFO and drains them as fixed-length write bursts to a memory-side valid/ready port, generating linear word addresses from a per-frame base. It tracks frame completion and flags data loss and protocol errors.

## Interface
- `FIFO_DEPTH`, 64 — FIFO entries. Power of two, ≥ 2×`BURST_LEN`.
- `BURST_LEN`, 16 — words per memory burst. Power of two.
- `ADDR_W`, 24 — memory word-address width.
- `FRAME_WORDS`, 259200 — 64-bit words per frame. Must be a multiple of `BURST_LEN`; elaboration error otherwise.

Ports:
- `par_clock` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `frame_start` in 1 — one-cycle pulse (recorder FS).
- `we` in 1 — input word valid.
- `pixels` in 64 — input word.
- `frame_base` in `ADDR_W` — word address of frame; sampled on accepted `frame_start`.
- `mem_valid` out 1 — burst beat valid.
- `mem_ready` in 1 — memory accepts beat.
- `mem_addr` out `ADDR_W` — address of current beat.
- `mem_data` out 64 — beat data.
- `mem_last` out 1 — final beat of burst.
- `frame_done` out 1 — one-cycle pulse, last word of frame written.
- `overflow` out 1 — sticky: input word dropped.
- `frame_error` out 1 — sticky: `frame_start` outside IDLE.

## Operation
States: IDLE, WAIT, BURST.

- **Reset:** state IDLE; FIFO empty; all outputs 0; `mem_addr`, word counter, and beat counter 0.
- **IDLE:**
  - `we` is ignored. Words are not stored and do not set `overflow`.
  - `frame_start` latches `frame_base` into `mem_addr`, zeroes the word counter, clears `overflow` and `frame_error`, and goes to WAIT.
  - If `we` is high in the same cycle as `frame_start`, that word is accepted into the new frame.
- **WAIT / BURST:**
  - `we`=1 with FIFO not full: word written.
  - `we`=1 with FIFO full: word dropped, `overflow` set.
  - Full is evaluated before that cycle's read; no simultaneous-read bypass.
- **WAIT → BURST:** when FIFO count ≥ `BURST_LEN`.
- **BURST:**
  - `mem_valid`=1 with `mem_data` = FIFO head (first-word fall-through).
  - Each beat with `mem_valid & mem_ready` pops the FIFO, increments `mem_addr` and the word counter, and advances the beat counter.
  - `mem_last`=1 when beat counter = `BURST_LEN`−1.
  - Once asserted, `mem_valid`, `mem_addr`, and `mem_data` stay stable until the beat is accepted.
- **Burst end** (handshake with `mem_last`):
  - If word counter reaches `FRAME_WORDS`: pulse `frame_done`, go to IDLE.
  - Otherwise: go to WAIT.
- **`frame_start` in WAIT or BURST:** ignored apart from setting `frame_error`; the current frame continues.
- **Address wrap:** `mem_addr` wraps modulo 2^`ADDR_W` with no flag.

## Timing
- Write at edge N is visible in FIFO count at N+1.
- WAIT→BURST decision is registered: `mem_valid` rises the cycle after count reaches `BURST_LEN`.
- With `mem_ready` held high, one beat per cycle: a burst takes exactly `BURST_LEN` cycles.
- Between bursts there is at least one cycle with `mem_valid`=0 (WAIT).
- `frame_done` is high the cycle after the final `mem_last` handshake.
- `reset` asserted mid-burst:
  - `mem_valid` is 0 on the next cycle.
  - FIFO contents are discarded.
  - The partial burst is abandoned; the memory side must tolerate this.

## Configuration
- `FRAME_WRITER_STATS_EN` defined:
  - Adds output `drop_count` [15:0]: count of dropped words, saturating at 0xFFFF.
  - Adds output `peak_level` [$clog2(`FIFO_DEPTH`):0]: highest FIFO count seen.
  - Both clear on reset and on accepted `frame_start`.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `vita2k_pkg` holds:
  - `PIX_W`=64.
  - The default `BURST_LEN` and `FRAME_WORDS` constants.
  - The state enum `fw_state_t` {IDLE, WAIT, BURST}.
- Sub-module `sync_fifo` (single clock, synchronous reset, FWFT, parameterised width/depth, exposes `count`) is instantiated once.
- The FSM, address generation, and flags live in `frame_writer`.

## Test plan
- **Nominal frame:** `FRAME_WORDS`=32, `BURST_LEN`=16, base 0x100; `frame_start` then 32 consecutive `we`, `mem_ready`=1 → two bursts at 0x100–0x10F and 0x110–0x11F in order; `mem_last` on beats 15 and 31; one `frame_done`.
- **Backpressure:** `mem_ready` toggling 1/0 each cycle mid-burst → `mem_addr` and `mem_data` held stable while stalled; no data lost or duplicated.
- **Overflow:** `FIFO_DEPTH`=32, `mem_ready`=0, 40 words written → exactly 8 dropped; `overflow`=1; with stats, `drop_count`=8 and `peak_level`=32.
- **Stray start:** `frame_start` during BURST → `frame_error`=1; addresses continue unchanged; the frame completes at the original base.
- **Reset mid-burst:** `reset` at beat 5 → `mem_valid`=0 next cycle, state IDLE; a new `frame_start` with base 0x800 → first beat at 0x800.
- **Idle words:** `we` pulses in IDLE without `frame_start` → no `mem_valid`; `overflow` stays 0.
